// File: rtl/rptr_handler_ctrl_if.sv
// Read-side bundle of the async FIFO: consumer request, synchronized write pointer,
// memory read port and the read-domain status/pointer outputs.
interface rptr_handler_ctrl_if #(
    parameter int PTR_WIDTH  = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  r_en;
    logic [PTR_WIDTH:0]    g_wptr_sync;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [PTR_WIDTH-1:0]  raddr;
    logic [PTR_WIDTH:0]    b_rptr;
    logic [PTR_WIDTH:0]    g_rptr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  almost_empty;
    logic [PTR_WIDTH:0]    rd_level;
    logic                  underflow;

    modport master (
        output r_en, g_wptr_sync, mem_rdata,
        input  raddr, b_rptr, g_rptr, data_out, empty, almost_empty, rd_level, underflow
    );

    modport slave (
        input  r_en, g_wptr_sync, mem_rdata,
        output raddr, b_rptr, g_rptr, data_out, empty, almost_empty, rd_level, underflow
    );
endinterface

// File: rtl/rptr_handler_ctrl.sv
// Async FIFO read-domain controller: read pointers, registered data and empty/level flags.
// Latency: pointers/data update on the accepting edge; flags follow g_wptr_sync after one edge.
// Backpressure: reads while empty are dropped with an underflow pulse. FIFO_FWFT_EN selects first-word-fall-through.
module rptr_handler_ctrl #(
    parameter int PTR_WIDTH  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AE_THRESH  = 2
) (
    input  logic                 rclk,
    input  logic                 rrst,
    rptr_handler_ctrl_if.slave   bus
);

    localparam logic [PTR_WIDTH:0] AE_LVL = AE_THRESH[PTR_WIDTH:0];

    logic [PTR_WIDTH:0]    b_rptr_q, b_rptr_d;
    logic [PTR_WIDTH:0]    g_rptr_q, g_rptr_d;
    logic [PTR_WIDTH:0]    rd_level_q, rd_level_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  empty_q, empty_d;
    logic                  almost_empty_q, almost_empty_d;
    logic                  underflow_q, underflow_d;

    logic [PTR_WIDTH:0]    b_wptr_s;
    logic [PTR_WIDTH:0]    mem_words;
    logic                  gray_acc;
    logic                  advance;

    // Gray-to-binary, MSB first: each binary bit is the XOR of all Gray bits above and at it.
    always_comb begin
        gray_acc = 1'b0;
        b_wptr_s = '0;
        for (int i = PTR_WIDTH; i >= 0; i--) begin
            gray_acc    = gray_acc ^ bus.g_wptr_sync[i];
            b_wptr_s[i] = gray_acc;
        end
    end

`ifdef FIFO_FWFT_EN
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_VALID = 1'b1;

    logic [0:0] state_q, state_d;
    logic       mem_nonempty;

    // The output register is a one-word stage ahead of memory; refill it whenever it drains.
    always_comb begin
        mem_nonempty = (g_rptr_q != bus.g_wptr_sync);
        advance      = mem_nonempty & ((state_q == ST_IDLE) | bus.r_en);
        state_d      = state_q;
        if (advance) begin
            state_d = ST_VALID;
        end else if ((state_q == ST_VALID) && bus.r_en) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`else
    always_comb begin
        advance = bus.r_en & ~empty_q;
    end
`endif

    always_comb begin
        b_rptr_d    = b_rptr_q + {{PTR_WIDTH{1'b0}}, advance};
        g_rptr_d    = (b_rptr_d >> 1) ^ b_rptr_d;
        mem_words   = b_wptr_s - b_rptr_d;
        data_out_d  = advance ? bus.mem_rdata : data_out_q;
        underflow_d = bus.r_en & empty_q;
`ifdef FIFO_FWFT_EN
        empty_d     = (state_d == ST_IDLE);
        rd_level_d  = mem_words + {{PTR_WIDTH{1'b0}}, (state_d == ST_VALID)};
`else
        // Full-width compare keeps the wrap bit, so a full FIFO never looks empty.
        empty_d     = (g_rptr_d == bus.g_wptr_sync);
        rd_level_d  = mem_words;
`endif
        almost_empty_d = (rd_level_d <= AE_LVL);
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            b_rptr_q       <= '0;
            g_rptr_q       <= '0;
            data_out_q     <= '0;
            rd_level_q     <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            underflow_q    <= 1'b0;
        end else begin
            b_rptr_q       <= b_rptr_d;
            g_rptr_q       <= g_rptr_d;
            data_out_q     <= data_out_d;
            rd_level_q     <= rd_level_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            underflow_q    <= underflow_d;
        end
    end

    assign bus.raddr        = b_rptr_q[PTR_WIDTH-1:0];
    assign bus.b_rptr       = b_rptr_q;
    assign bus.g_rptr       = g_rptr_q;
    assign bus.data_out     = data_out_q;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.rd_level     = rd_level_q;
    assign bus.underflow    = underflow_q;

    a_gray_one_bit: assert property (@(posedge rclk) disable iff (rrst)
        $countones(g_rptr_q ^ $past(g_rptr_q)) <= 1);

    a_empty_matches_level: assert property (@(posedge rclk) disable iff (rrst)
        empty_q == (rd_level_q == '0));

endmodule

// File: tb/tb_rptr_handler_ctrl.sv
// Directed bench for rptr_handler_ctrl with PTR_WIDTH=3, AE_THRESH=2; memory returns raddr+8'hA0.
module tb_rptr_handler_ctrl;

    logic rclk;
    logic rrst;
    int   n_checks;
    int   n_fail;

    rptr_handler_ctrl_if #(.PTR_WIDTH(3), .DATA_WIDTH(8)) bus ();

    rptr_handler_ctrl #(.PTR_WIDTH(3), .DATA_WIDTH(8), .AE_THRESH(2)) dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus)
    );

    assign bus.mem_rdata = 8'(bus.raddr) + 8'hA0;

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick;
        @(posedge rclk);
        #1;
    endtask

    task automatic test_reset;
        rrst = 1'b1;
        bus.r_en = 1'b0;
        bus.g_wptr_sync = 4'b0000;
        tick;
        tick;
        n_checks++; if (bus.b_rptr !== 4'd0) begin n_fail++; $display("FAIL reset_b_rptr: got %h exp 0", bus.b_rptr); end
        n_checks++; if (bus.g_rptr !== 4'd0) begin n_fail++; $display("FAIL reset_g_rptr: got %h exp 0", bus.g_rptr); end
        n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h exp 00", bus.data_out); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b exp 1", bus.empty); end
        n_checks++; if (bus.almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae: got %b exp 1", bus.almost_empty); end
        n_checks++; if (bus.rd_level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d exp 0", bus.rd_level); end
        n_checks++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b exp 0", bus.underflow); end
        rrst = 1'b0;
        tick;
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL post_reset_empty: got %b exp 1", bus.empty); end
    endtask

    // Raise rrst between edges and check outputs before any clock edge arrives.
    task automatic test_async_reset;
        @(posedge rclk);
        #2;
        rrst = 1'b1;
        #1;
        n_checks++; if (bus.b_rptr !== 4'd0) begin n_fail++; $display("FAIL arst_b_rptr: got %h exp 0", bus.b_rptr); end
        n_checks++; if (bus.g_rptr !== 4'd0) begin n_fail++; $display("FAIL arst_g_rptr: got %h exp 0", bus.g_rptr); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL arst_empty: got %b exp 1", bus.empty); end
        n_checks++; if (bus.almost_empty !== 1'b1) begin n_fail++; $display("FAIL arst_ae: got %b exp 1", bus.almost_empty); end
        n_checks++; if (bus.rd_level !== 4'd0) begin n_fail++; $display("FAIL arst_level: got %0d exp 0", bus.rd_level); end
        n_checks++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL arst_underflow: got %b exp 0", bus.underflow); end
        n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL arst_data: got %h exp 00", bus.data_out); end
        tick;
        n_checks++; if (bus.b_rptr !== 4'd0) begin n_fail++; $display("FAIL arst_hold_b_rptr: got %h exp 0", bus.b_rptr); end
        bus.r_en = 1'b0;
        rrst = 1'b0;
    endtask

`ifdef FIFO_FWFT_EN
    task automatic test_fwft;
        logic [7:0] exp_d [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA3};
        logic [3:0] exp_l [4] = '{4'd3, 4'd2, 4'd1, 4'd0};
        bus.g_wptr_sync = gray(4'd1);
        bus.r_en = 1'b0;
        tick;
        n_checks++; if (bus.data_out !== 8'hA0) begin n_fail++; $display("FAIL fwft_head_data: got %h exp a0", bus.data_out); end
        n_checks++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL fwft_head_empty: got %b exp 0", bus.empty); end
        n_checks++; if (bus.rd_level !== 4'd1) begin n_fail++; $display("FAIL fwft_head_level: got %0d exp 1", bus.rd_level); end
        n_checks++; if (bus.b_rptr !== 4'd1) begin n_fail++; $display("FAIL fwft_head_b_rptr: got %h exp 1", bus.b_rptr); end
        bus.r_en = 1'b1;
        tick;
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL fwft_pop_empty: got %b exp 1", bus.empty); end
        n_checks++; if (bus.rd_level !== 4'd0) begin n_fail++; $display("FAIL fwft_pop_level: got %0d exp 0", bus.rd_level); end
        n_checks++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL fwft_pop_underflow: got %b exp 0", bus.underflow); end
        tick;
        n_checks++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL fwft_underflow: got %b exp 1", bus.underflow); end
        n_checks++; if (bus.b_rptr !== 4'd1) begin n_fail++; $display("FAIL fwft_underflow_b_rptr: got %h exp 1", bus.b_rptr); end
        bus.r_en = 1'b0;
        bus.g_wptr_sync = gray(4'd4);
        tick;
        n_checks++; if (bus.data_out !== 8'hA1) begin n_fail++; $display("FAIL fwft_refill_data: got %h exp a1", bus.data_out); end
        n_checks++; if (bus.rd_level !== 4'd3) begin n_fail++; $display("FAIL fwft_refill_level: got %0d exp 3", bus.rd_level); end
        bus.r_en = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick;
            n_checks++; if (bus.data_out !== exp_d[i]) begin n_fail++; $display("FAIL fwft_stream_data[%0d]: got %h exp %h", i, bus.data_out, exp_d[i]); end
            n_checks++; if (bus.rd_level !== exp_l[i]) begin n_fail++; $display("FAIL fwft_stream_level[%0d]: got %0d exp %0d", i, bus.rd_level, exp_l[i]); end
            n_checks++; if (bus.empty !== (i == 3)) begin n_fail++; $display("FAIL fwft_stream_empty[%0d]: got %b exp %b", i, bus.empty, (i == 3)); end
        end
        bus.r_en = 1'b0;
    endtask
`else
    task automatic test_level_flags;
        bus.g_wptr_sync = 4'b0111;
        bus.r_en = 1'b0;
        tick;
        n_checks++; if (bus.rd_level !== 4'd5) begin n_fail++; $display("FAIL level5_level: got %0d exp 5", bus.rd_level); end
        n_checks++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL level5_empty: got %b exp 0", bus.empty); end
        n_checks++; if (bus.almost_empty !== 1'b0) begin n_fail++; $display("FAIL level5_ae: got %b exp 0", bus.almost_empty); end
        n_checks++; if (bus.b_rptr !== 4'd0) begin n_fail++; $display("FAIL level5_b_rptr: got %h exp 0", bus.b_rptr); end
    endtask

    task automatic test_read_to_empty;
        logic [3:0] exp_l;
        logic [7:0] exp_d;
        for (int i = 0; i < 5; i++) begin
            bus.r_en = 1'b1;
            tick;
            exp_l = 4'(4 - i);
            exp_d = 8'(8'hA0 + i);
            n_checks++; if (bus.data_out !== exp_d) begin n_fail++; $display("FAIL rd_data[%0d]: got %h exp %h", i, bus.data_out, exp_d); end
            n_checks++; if (bus.b_rptr !== 4'(i + 1)) begin n_fail++; $display("FAIL rd_b_rptr[%0d]: got %h exp %h", i, bus.b_rptr, 4'(i + 1)); end
            n_checks++; if (bus.rd_level !== exp_l) begin n_fail++; $display("FAIL rd_level[%0d]: got %0d exp %0d", i, bus.rd_level, exp_l); end
            n_checks++; if (bus.empty !== (i == 4)) begin n_fail++; $display("FAIL rd_empty[%0d]: got %b exp %b", i, bus.empty, (i == 4)); end
            n_checks++; if (bus.almost_empty !== (exp_l <= 4'd2)) begin n_fail++; $display("FAIL rd_ae[%0d]: got %b exp %b", i, bus.almost_empty, (exp_l <= 4'd2)); end
        end
    endtask

    task automatic test_underflow;
        bus.r_en = 1'b1;
        tick;
        n_checks++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL uf_pulse: got %b exp 1", bus.underflow); end
        n_checks++; if (bus.b_rptr !== 4'd5) begin n_fail++; $display("FAIL uf_b_rptr: got %h exp 5", bus.b_rptr); end
        n_checks++; if (bus.data_out !== 8'hA4) begin n_fail++; $display("FAIL uf_data: got %h exp a4", bus.data_out); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL uf_empty: got %b exp 1", bus.empty); end
        bus.r_en = 1'b0;
        tick;
        n_checks++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL uf_clear: got %b exp 0", bus.underflow); end
    endtask

    task automatic test_wrap;
        logic [3:0] b_old;
        logic [3:0] b_new;
        logic [3:0] exp_l;
        // Writer stays four ahead so every one of 16 reads is accepted.
        b_new = 4'd5;
        bus.g_wptr_sync = gray(4'd8);
        tick;
        n_checks++; if (bus.rd_level !== 4'd3) begin n_fail++; $display("FAIL wrap_pre_level: got %0d exp 3", bus.rd_level); end
        for (int i = 0; i < 16; i++) begin
            b_old = b_new;
            b_new = b_old + 4'd1;
            bus.g_wptr_sync = gray(b_old + 4'd4);
            bus.r_en = 1'b1;
            tick;
            n_checks++; if (bus.b_rptr !== b_new) begin n_fail++; $display("FAIL wrap_b_rptr[%0d]: got %h exp %h", i, bus.b_rptr, b_new); end
            n_checks++; if (bus.g_rptr !== gray(b_new)) begin n_fail++; $display("FAIL wrap_g_rptr[%0d]: got %h exp %h", i, bus.g_rptr, gray(b_new)); end
            n_checks++; if (bus.data_out !== 8'(8'hA0 + b_old[2:0])) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h exp %h", i, bus.data_out, 8'(8'hA0 + b_old[2:0])); end
            n_checks++; if (bus.rd_level !== 4'd3 || bus.empty !== 1'b0) begin n_fail++; $display("FAIL wrap_flags[%0d]: got level %0d empty %b exp level 3 empty 0", i, bus.rd_level, bus.empty); end
            if (b_old == 4'd15) begin
                n_checks++; if (bus.g_rptr !== 4'b0000) begin n_fail++; $display("FAIL wrap_g_zero: got %b exp 0000", bus.g_rptr); end
            end
        end
        bus.r_en = 1'b0;
        bus.g_wptr_sync = gray(4'd13);
        tick;
        n_checks++; if (bus.rd_level !== 4'd8 || bus.empty !== 1'b0) begin n_fail++; $display("FAIL full_flags: got level %0d empty %b exp level 8 empty 0", bus.rd_level, bus.empty); end
        bus.r_en = 1'b1;
        tick;
        tick;
        tick;
        n_checks++; if (bus.b_rptr !== 4'd8 || bus.rd_level !== 4'd5) begin n_fail++; $display("FAIL drain3: got b %h level %0d exp b 8 level 5", bus.b_rptr, bus.rd_level); end
        // Last word sits at pointer 15: the wrapping read must raise empty at that same edge.
        bus.g_wptr_sync = 4'b0000;
        b_new = 4'd8;
        for (int i = 0; i < 8; i++) begin
            b_new = b_new + 4'd1;
            exp_l = 4'd0 - b_new;
            tick;
            n_checks++; if (bus.b_rptr !== b_new) begin n_fail++; $display("FAIL wrapend_b_rptr[%0d]: got %h exp %h", i, bus.b_rptr, b_new); end
            n_checks++; if (bus.rd_level !== exp_l) begin n_fail++; $display("FAIL wrapend_level[%0d]: got %0d exp %0d", i, bus.rd_level, exp_l); end
            n_checks++; if (bus.empty !== (b_new == 4'd0)) begin n_fail++; $display("FAIL wrapend_empty[%0d]: got %b exp %b", i, bus.empty, (b_new == 4'd0)); end
        end
        n_checks++; if (bus.g_rptr !== 4'b0000) begin n_fail++; $display("FAIL wrapend_g_rptr: got %b exp 0000", bus.g_rptr); end
        bus.r_en = 1'b0;
    endtask

    task automatic test_back_to_back_then_reset;
        bus.g_wptr_sync = gray(4'd5);
        tick;
        bus.r_en = 1'b1;
        tick;
        tick;
        tick;
        n_checks++; if (bus.b_rptr !== 4'd3 || bus.data_out !== 8'hA2) begin n_fail++; $display("FAIL b2b_state: got b %h data %h exp b 3 data a2", bus.b_rptr, bus.data_out); end
        test_async_reset;
        tick;
        n_checks++; if (bus.rd_level !== 4'd5 || bus.empty !== 1'b0) begin n_fail++; $display("FAIL post_arst_level: got level %0d empty %b exp level 5 empty 0", bus.rd_level, bus.empty); end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rrst = 1'b1;
        bus.r_en = 1'b0;
        bus.g_wptr_sync = '0;
        test_reset;
`ifdef FIFO_FWFT_EN
        test_fwft;
        test_async_reset;
        tick;
        n_checks++; if (bus.empty !== 1'b0 || bus.rd_level !== 4'd4 || bus.data_out !== 8'hA0) begin n_fail++; $display("FAIL fwft_post_arst: got empty %b level %0d data %h exp 0 4 a0", bus.empty, bus.rd_level, bus.data_out); end
`else
        test_level_flags;
        test_read_to_empty;
        test_underflow;
        test_wrap;
        test_back_to_back_then_reset;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
